alu_opfetch: RTL and testbench

Operand-fetch and write-back sequencer that sits directly upstream of the 3-bit-opcode ALU and owns the 32×32 register file. It accepts one MIPS R-type instruction per handshake and reads `rs` and `rt`. It drives the ALU operand and opcode inputs from registers, captures the ALU result and flags, and writes the result to `rd`. It is the first sequential stage of the single-issue datapath and replaces hand-driven ALU stimulus.

---
 rtl/alu_pkg.sv | 79 +++++++
 rtl/alu_opfetch_reg_file.sv | 44 ++++
 rtl/alu_opfetch.sv | 148 ++++++++++++++
 tb/tb_alu_opfetch.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, state encoding and instruction decode for the
// operand-fetch / write-back sequencer.
package alu_pkg;

    // R-type instruction field bit positions
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;
    localparam int unsigned RS_HI  = 25;
    localparam int unsigned RS_LO  = 21;
    localparam int unsigned RT_HI  = 20;
    localparam int unsigned RT_LO  = 16;
    localparam int unsigned RD_HI  = 15;
    localparam int unsigned RD_LO  = 11;
    localparam int unsigned SH_HI  = 10;
    localparam int unsigned SH_LO  = 6;
    localparam int unsigned FN_HI  = 5;
    localparam int unsigned FN_LO  = 0;

    // Primary opcode of every accepted instruction
    localparam logic [5:0] OPC_RTYPE = 6'h00;

    // funct codes
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLTU = 6'h2B;
    localparam logic [5:0] FN_SLLV = 6'h04;

    // ALU opcode encodings
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        WB     = 2'b11
    } state_t;

    typedef struct packed {
        logic       legal;
        logic [2:0] op;
        logic       swap;   // operands presented as {rt, rs} instead of {rs, rt}
    } decode_t;

    // Map op/funct to ALU control; anything unrecognised is illegal
    function automatic decode_t decode_fields(input logic [5:0] opc, input logic [5:0] fn);
        decode_t d;
        d = '0;
        if (opc == OPC_RTYPE) begin
            d.legal = 1'b1;
            case (fn)
                FN_AND:  d.op = OP_AND;
                FN_OR:   d.op = OP_OR;
                FN_XOR:  d.op = OP_XOR;
                FN_NOR:  d.op = OP_NOR;
                FN_ADD:  d.op = OP_ADD;
                FN_SUB:  d.op = OP_SUB;
                FN_SLTU: d.op = OP_SLT;
                FN_SLLV: begin
                    d.op   = OP_SHL;
                    d.swap = 1'b1;
                end
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_opfetch_reg_file.sv
// 2^AW x DW register file: two combinational read ports, a debug read
// port and one synchronous write port. Register 0 always reads as zero.
module reg_file
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr_a,
    output logic [DW-1:0] rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];

    // Storage: cleared on reset, writes to address 0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Combinational reads with address 0 forced to zero
    always_comb begin
        rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
        dbg_data  = (dbg_addr  == '0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: rtl/alu_opfetch.sv
// Operand-fetch and write-back sequencer in front of the 3-bit-opcode ALU.
// Accepts one R-type instruction per handshake, presents registered
// operands to the ALU, captures its result and writes it back to rd.
module alu_opfetch
    import alu_pkg::*;
#(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_instr,
    output logic [DW-1:0] ALU_A,
    output logic [DW-1:0] ALU_B,
    output logic [2:0]    ALU_OP,
    input  logic [DW-1:0] alu_f,
    input  logic          alu_zf,
    input  logic          alu_of,
    output logic          done,
    output logic          err,
    output logic [1:0]    flags,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_t        state;
    state_t        state_nxt;

    logic [5:0]    opc_q;
    logic [5:0]    fn_q;
    logic [4:0]    rs_q;
    logic [4:0]    rt_q;
    logic [4:0]    rd_q;

    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] res_f;
    logic          res_zf;
    logic          res_of;

    decode_t       dec;
    logic          wr_en;
    logic          shamt_unused;

    assign in_ready     = (state == IDLE);
    assign dec          = decode_fields(opc_q, fn_q);
    assign wr_en        = (state == WB) && dec.legal && (rd_q != 5'd0);
    assign shamt_unused = ^in_instr[SH_HI:SH_LO];

    reg_file #(
        .DW (DW),
        .AW (AW)
    ) u_reg_file (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (AW'(rs_q)),
        .rd_data_a (rs_data),
        .rd_addr_b (AW'(rt_q)),
        .rd_data_b (rt_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (AW'(rd_q)),
        .wr_data   (res_f)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: wait for a handshake, then a fixed decode/exec/wb walk
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Instruction latch, ALU drive, result capture and retire signalling
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_q  <= '0;
            fn_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            rd_q   <= '0;
            ALU_A  <= '0;
            ALU_B  <= '0;
            ALU_OP <= OP_AND;
            res_f  <= '0;
            res_zf <= 1'b0;
            res_of <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            flags  <= 2'b00;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opc_q <= in_instr[OPC_HI:OPC_LO];
                        fn_q  <= in_instr[FN_HI:FN_LO];
                        rs_q  <= in_instr[RS_HI:RS_LO];
                        rt_q  <= in_instr[RT_HI:RT_LO];
                        rd_q  <= in_instr[RD_HI:RD_LO];
                    end
                end
                DECODE: begin
                    if (dec.legal) begin
                        ALU_OP <= dec.op;
                        ALU_A  <= dec.swap ? rt_data : rs_data;
                        ALU_B  <= dec.swap ? rs_data : rt_data;
                    end else begin
                        ALU_OP <= OP_AND;
                        ALU_A  <= '0;
                        ALU_B  <= '0;
                    end
                end
                EXEC: begin
                    res_f  <= alu_f;
                    res_zf <= alu_zf;
                    res_of <= alu_of;
                end
                WB: begin
                    done <= 1'b1;
                    err  <= ~dec.legal;
                    if (dec.legal) begin
                        flags <= {res_zf, res_of};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_opfetch.sv
// Directed bench for alu_opfetch with a behavioural ALU closing the loop.
module tb_alu_opfetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [2:0]  ALU_OP;
    logic [31:0] alu_f;
    logic        alu_zf;
    logic        alu_of;
    logic        done;
    logic        err;
    logic [1:0]  flags;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_vec  = 0;
    int n_fail = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    alu_opfetch #(.DW(32), .AW(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .ALU_A    (ALU_A),
        .ALU_B    (ALU_B),
        .ALU_OP   (ALU_OP),
        .alu_f    (alu_f),
        .alu_zf   (alu_zf),
        .alu_of   (alu_of),
        .done     (done),
        .err      (err),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // ALU model: OF is carry-out for add and borrow for sub
    logic [32:0] sum;
    always_comb begin
        sum    = '0;
        alu_f  = '0;
        alu_of = 1'b0;
        case (ALU_OP)
            3'b000: alu_f = ALU_A & ALU_B;
            3'b001: alu_f = ALU_A | ALU_B;
            3'b010: alu_f = ALU_A ^ ALU_B;
            3'b011: alu_f = ~(ALU_A | ALU_B);
            3'b100: begin
                sum    = {1'b0, ALU_A} + {1'b0, ALU_B};
                alu_f  = sum[31:0];
                alu_of = sum[32];
            end
            3'b101: begin
                alu_f  = ALU_A - ALU_B;
                alu_of = (ALU_A < ALU_B);
            end
            3'b110: alu_f = (ALU_A < ALU_B) ? 32'd1 : 32'd0;
            default: alu_f = ALU_A << ALU_B[4:0];
        endcase
        alu_zf = (alu_f == 32'd0);
    end

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [2:0]  exp_op;
        logic        exp_err;
        logic [1:0]  exp_flags;
        logic [4:0]  chk_addr;
        logic [31:0] chk_val;
    } vec_t;

    vec_t vecs[15];

    function automatic logic [31:0] enc(input logic [5:0] opc, input int rs, input int rt,
                                        input int rd, input int sh, input logic [5:0] fn);
        return {opc, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] instr,
                                input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                input logic e, input logic [1:0] fl, input int ca,
                                input logic [31:0] cv);
        vec_t v;
        v.name = name; v.instr = instr; v.exp_a = a; v.exp_b = b; v.exp_op = op;
        v.exp_err = e; v.exp_flags = fl; v.chk_addr = 5'(ca); v.chk_val = cv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input int a, output logic [31:0] d);
        dbg_addr = 5'(a);
        #1;
        d = dbg_data;
    endtask

    // Present instr from a negedge and return at the negedge after the accept edge
    task automatic accept(input logic [31:0] instr, output bit ok);
        int k;
        in_instr = instr;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = in_ready;
        if (!ok) begin
            n_vec++; n_fail++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        logic [31:0] d;
        accept(v.instr, ok);
        if (ok) begin
            chk({v.name, "/done_n+0"}, 32'(done), 32'd0);
            @(negedge clk);
            chk({v.name, "/alu_a"}, ALU_A, v.exp_a);
            chk({v.name, "/alu_b"}, ALU_B, v.exp_b);
            chk({v.name, "/alu_op"}, 32'(ALU_OP), 32'(v.exp_op));
            chk({v.name, "/done_n+1"}, 32'(done), 32'd0);
            @(negedge clk);
            chk({v.name, "/done_n+2"}, 32'(done), 32'd0);
            @(negedge clk);
            chk({v.name, "/done_n+3"}, 32'(done), 32'd1);
            chk({v.name, "/err"}, 32'(err), 32'(v.exp_err));
            chk({v.name, "/flags"}, 32'(flags), 32'(v.exp_flags));
            chk({v.name, "/in_ready"}, 32'(in_ready), 32'd1);
            chk({v.name, "/alu_a_hold"}, ALU_A, v.exp_a);
            read_reg(int'(v.chk_addr), d);
            chk({v.name, "/reg"}, d, v.chk_val);
        end
    endtask

    // Two instructions with in_valid held high; accepts must be 4 cycles apart
    task automatic back_to_back(input string name, input logic [31:0] i1, input logic [31:0] i2);
        int cyc;
        int first;
        int second;
        first  = -1;
        second = -1;
        in_instr = i1;
        in_valid = 1'b1;
        cyc = 0;
        while (second < 0 && cyc < 40) begin
            if (in_ready) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            @(negedge clk);
            cyc++;
            if (first >= 0 && second < 0) in_instr = i2;
        end
        in_valid = 1'b0;
        chk({name, "/accept_gap"}, 32'(second - first), 32'd4);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        bit ok;
        int dc;

        vecs[0]  = mk("nor_r1",   enc(6'h00, 0, 0, 1, 0, 6'h27), 32'h0, 32'h0, 3'b011, 1'b0, 2'b00, 1, 32'hFFFF_FFFF);
        vecs[1]  = mk("sltu_r2",  enc(6'h00, 0, 1, 2, 0, 6'h2B), 32'h0, 32'hFFFF_FFFF, 3'b110, 1'b0, 2'b00, 2, 32'h1);
        vecs[2]  = mk("and_r11",  enc(6'h00, 1, 2, 11, 0, 6'h24), 32'hFFFF_FFFF, 32'h1, 3'b000, 1'b0, 2'b00, 11, 32'h1);
        vecs[3]  = mk("add_ovf",  enc(6'h00, 1, 2, 3, 0, 6'h20), 32'hFFFF_FFFF, 32'h1, 3'b100, 1'b0, 2'b11, 3, 32'h0);
        vecs[4]  = mk("add_r10",  enc(6'h00, 2, 2, 10, 0, 6'h20), 32'h1, 32'h1, 3'b100, 1'b0, 2'b00, 10, 32'h2);
        vecs[5]  = mk("sllv_r4",  enc(6'h00, 10, 2, 4, 0, 6'h04), 32'h1, 32'h2, 3'b111, 1'b0, 2'b00, 4, 32'h4);
        vecs[6]  = mk("or_r5",    enc(6'h00, 2, 0, 5, 0, 6'h25), 32'h1, 32'h0, 3'b001, 1'b0, 2'b00, 5, 32'h1);
        vecs[7]  = mk("sllv_r6",  enc(6'h00, 4, 5, 6, 0, 6'h04), 32'h1, 32'h4, 3'b111, 1'b0, 2'b00, 6, 32'h10);
        vecs[8]  = mk("xor_r12",  enc(6'h00, 1, 5, 12, 0, 6'h26), 32'hFFFF_FFFF, 32'h1, 3'b010, 1'b0, 2'b00, 12, 32'hFFFF_FFFE);
        vecs[9]  = mk("sub_r13",  enc(6'h00, 2, 1, 13, 0, 6'h22), 32'h1, 32'hFFFF_FFFF, 3'b101, 1'b0, 2'b01, 13, 32'h2);
        vecs[10] = mk("ill_op",   enc(6'h08, 1, 2, 5, 0, 6'h20), 32'h0, 32'h0, 3'b000, 1'b1, 2'b01, 5, 32'h1);
        vecs[11] = mk("ill_fn",   enc(6'h00, 1, 2, 6, 0, 6'h21), 32'h0, 32'h0, 3'b000, 1'b1, 2'b01, 6, 32'h10);
        vecs[12] = mk("add_r0",   enc(6'h00, 1, 1, 0, 0, 6'h20), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 1'b0, 2'b01, 0, 32'h0);
        vecs[13] = mk("and_zero", enc(6'h00, 1, 0, 16, 0, 6'h24), 32'hFFFF_FFFF, 32'h0, 3'b000, 1'b0, 2'b10, 16, 32'h0);
        vecs[14] = mk("add_shamt", enc(6'h00, 2, 4, 17, 31, 6'h20), 32'h1, 32'h4, 3'b100, 1'b0, 2'b00, 17, 32'h5);

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst/in_ready", 32'(in_ready), 32'd1);
        chk("rst/flags", 32'(flags), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/err", 32'(err), 32'd0);
        chk("rst/alu_a", ALU_A, 32'd0);
        chk("rst/alu_b", ALU_B, 32'd0);
        chk("rst/alu_op", 32'(ALU_OP), 32'd0);
        for (int a = 0; a < 32; a++) begin
            read_reg(a, d);
            chk($sformatf("rst/reg%0d", a), d, 32'd0);
        end
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i]);
        end

        // Read-after-write with in_valid held high
        back_to_back("raw1", enc(6'h00, 2, 2, 7, 0, 6'h22), enc(6'h00, 7, 2, 8, 0, 6'h2B));
        read_reg(7, d);
        chk("raw1/r7", d, 32'd0);
        read_reg(8, d);
        chk("raw1/r8", d, 32'd1);
        back_to_back("raw2", enc(6'h00, 2, 2, 18, 0, 6'h20), enc(6'h00, 2, 18, 19, 0, 6'h2B));
        read_reg(18, d);
        chk("raw2/r18", d, 32'd2);
        read_reg(19, d);
        chk("raw2/r19", d, 32'd1);
        chk("raw2/flags", 32'(flags), 32'd0);
        @(negedge clk);

        // Reset while the instruction is in EXEC
        dc = done_cnt;
        accept(enc(6'h00, 1, 2, 9, 0, 6'h25), ok);
        @(negedge clk);
        chk("rstmid/alu_a_loaded", ALU_A, 32'hFFFF_FFFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid/in_ready", 32'(in_ready), 32'd1);
        chk("rstmid/alu_a", ALU_A, 32'd0);
        repeat (4) @(negedge clk);
        chk("rstmid/no_done", 32'(done_cnt - dc), 32'd0);
        read_reg(9, d);
        chk("rstmid/r9", d, 32'd0);
        read_reg(1, d);
        chk("rstmid/r1", d, 32'd0);
        chk("rstmid/flags", 32'(flags), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
